// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the E-stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, D1, D2, input Busy, HI, LO);
  modport slave  (input Start, MDOp, D1, D2, output Busy, HI, LO);
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define HILO_MULDIV_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
//
// state | meaning
// IDLE  | accepts Start; mthi/mtlo write HI/LO directly
// RUN   | result held in PHI/PLO, counter running down, Start ignored
module hilo_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  hilo_muldiv_if.slave bus
);

  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, phi_q, plo_q;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               is_multi;
  logic [CW-1:0]      lat;

  assign prod_s  = $signed({{32{bus.D1[31]}}, bus.D1}) * $signed({{32{bus.D2[31]}}, bus.D2});
  assign prod_u  = {32'd0, bus.D1} * {32'd0, bus.D2};
  // Divisor forced to 1 on zero so no X ever reaches PHI/PLO; that result is discarded anyway.
  assign divisor = (bus.D2 == 32'd0) ? 32'd1 : bus.D2;
  assign quot_s  = $signed(bus.D1) / $signed(divisor);
  assign rem_s   = $signed(bus.D1) % $signed(divisor);
  assign quot_u  = bus.D1 / divisor;
  assign rem_u   = bus.D1 % divisor;

`ifdef HILO_MULDIV_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  always_comb begin
    res_hi   = hi_q;
    res_lo   = lo_q;
    is_multi = 1'b0;
    lat      = '0;
    case (bus.MDOp)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
      OP_DIV: begin
        if (bus.D2 != 32'd0) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
        is_multi = 1'b1;
        lat      = DIV_LAT;
      end
      OP_DIVU: begin
        if (bus.D2 != 32'd0) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
        is_multi = 1'b1;
        lat      = DIV_LAT;
      end
`ifdef HILO_MULDIV_MADD_EN
      OP_MADD: begin
        {res_hi, res_lo} = acc + prod_s;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
      OP_MADDU: begin
        {res_hi, res_lo} = acc + prod_u;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
      OP_MSUB: begin
        {res_hi, res_lo} = acc - prod_s;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
      OP_MSUBU: begin
        {res_hi, res_lo} = acc - prod_u;
        is_multi = 1'b1;
        lat      = MULT_LAT;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (is_multi) begin
              phi_q  <= res_hi;
              plo_q  <= res_lo;
              cnt    <= lat;
              busy_q <= 1'b1;
              state  <= RUN;
            end else if (bus.MDOp == OP_MTHI) begin
              hi_q <= bus.D1;
            end else if (bus.MDOp == OP_MTLO) begin
              lo_q <= bus.D1;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi_q   <= phi_q;
            lo_q   <= plo_q;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv; accumulate expectations follow HILO_MULDIV_MADD_EN.
module tb_hilo_muldiv;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_if bus ();

  hilo_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one op, count Busy cycles (bounded), verify HI/LO held while busy and final values.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input int exp_busy,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    cyc = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = op; bus.D1 = d1; bus.D2 = d2;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    while (bus.Busy === 1'b1 && cyc < 40) begin
      check({tag, " held HI"}, bus.HI, m_hi);
      check({tag, " held LO"}, bus.LO, m_lo);
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(cyc), 32'(exp_busy));
    check({tag, " HI"}, bus.HI, exp_hi);
    check({tag, " LO"}, bus.LO, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    bus.Start = 1'b0; bus.MDOp = 4'd0; bus.D1 = 32'd0; bus.D2 = 32'd0;
    reset = 1'b1;
    #2;
    check("reset Busy", {31'd0, bus.Busy}, 32'd0);
    check("reset HI", bus.HI, 32'd0);
    check("reset LO", bus.LO, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    do_op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    do_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    do_op("mthi", 4'd5, 32'h1234, 32'd0, 0, 32'h1234, 32'd3);
    do_op("mtlo", 4'd6, 32'h5678, 32'd0, 0, 32'h1234, 32'h5678);
    do_op("div0", 4'd3, 32'h55, 32'd0, 10, 32'h1234, 32'h5678);
    do_op("reserved", 4'd11, 32'hDEAD, 32'h3, 0, 32'h1234, 32'h5678);

    // mthi pulsed during cycle 2 of RUN must be dropped.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 4'd1; bus.D1 = 32'd3; bus.D2 = 32'd4;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 4'd5; bus.D1 = 32'hAAAA;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 40) begin cyc++; @(negedge clk); end
    check("ign busy tail", 32'(cyc), 32'd3);
    check("ign HI", bus.HI, 32'd0);
    check("ign LO", bus.LO, 32'd12);
    m_hi = 32'd0; m_lo = 32'd12;

    // Start on the commit edge T0+N is ignored; at T0+N+1 it is accepted.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 4'd1; bus.D1 = 32'd1; bus.D2 = 32'd1;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    repeat (4) @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 4'd5; bus.D1 = 32'hBEEF;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    check("edge busy", {31'd0, bus.Busy}, 32'd0);
    check("edge HI", bus.HI, 32'd0);
    check("edge LO", bus.LO, 32'd1);
    m_hi = 32'd0; m_lo = 32'd1;
    do_op("next mthi", 4'd5, 32'hBEEF, 32'd0, 0, 32'hBEEF, 32'd1);

    // Reset at cycle 4 of a div clears outputs without a clock edge.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = 4'd3; bus.D1 = 32'd100; bus.D2 = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0; bus.MDOp = 4'd0;
    repeat (3) @(negedge clk);
    check("pre-rst busy", {31'd0, bus.Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst Busy", {31'd0, bus.Busy}, 32'd0);
    check("async rst HI", bus.HI, 32'd0);
    check("async rst LO", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    do_op("divu post-rst", 4'd4, 32'd9, 32'd4, 10, 32'd1, 32'd2);

    do_op("madd setup hi", 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd2);
    do_op("madd setup lo", 4'd6, 32'd5, 32'd0, 0, 32'd0, 32'd5);
`ifdef HILO_MULDIV_MADD_EN
    do_op("madd", 4'd7, 32'd3, 32'd4, 5, 32'd0, 32'd17);
    do_op("msub", 4'd9, 32'd2, 32'd9, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    do_op("madd off", 4'd7, 32'd3, 32'd4, 0, 32'd0, 32'd5);
    do_op("msub off", 4'd9, 32'd2, 32'd9, 0, 32'd0, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the E stage and receives operations issued from it.
- Accepts one operation per start pulse and asserts `Busy` for a fixed latency, so hazard logic can stall later HI/LO users.
- Commits results to HI/LO at the end of the operation.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/multu/madd-family ops.
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu.

Ports:
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `Start`  input  1  issue strobe; qualifies `MDOp`, `D1`, `D2` on the current edge.
- `MDOp`  input  4  operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu.
  - 11–15 reserved (no-op).
- `D1`  input  32  rs operand, already forwarded by E-stage MUXes.
- `D2`  input  32  rt operand, already forwarded by E-stage MUXes.
- `Busy`  output  1  high while a multi-cycle op is in flight.
- `HI`  output  32  architectural HI register (mfhi source).
- `LO`  output  32  architectural LO register (mflo source).

## Operation

State machine with two states.
- IDLE
  - `Start`=1 with a multi-cycle op (1–4, or 7–10 when enabled):
    - latch the computed result into pending registers PHI/PLO;
    - load the counter with the latency;
    - go to RUN.
  - `Start`=1 with mthi/mtlo: write `D1` to HI/LO on that edge and stay in IDLE.
  - `Start`=0, `MDOp`=0, or a reserved code: no effect.
- RUN
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: HI←PHI, LO←PLO, go to IDLE.
  - `Start` while in RUN is ignored entirely (no queueing). The E-stage stall logic must hold the issuing instruction.

Arithmetic:
- mult: signed 32×32→64, HI=upper 32 bits, LO=lower 32 bits.
- multu: same as mult, unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder carrying the sign of `D1`.
- divu: unsigned quotient/remainder.
- Divide by zero (`D2`=0):
  - runs the full `DIV_CYCLES`;
  - PHI/PLO are loaded with the current HI/LO, so the values are unchanged at commit.
- mthi/mtlo: copy `D1` only; the other register is untouched.
- madd/maddu/msub/msubu:
  - {HI,LO} ± product, modulo 2^64;
  - signed or unsigned product as per the opcode;
  - {HI,LO} is sampled at issue.

## Timing

- Reset values: `Busy`=0, HI=0, LO=0, state IDLE, counter 0, PHI=PLO=0.
- Let T0 be the issue edge.
  - `Busy` is high from after T0 until edge T0+N, where N is the op's latency.
  - HI/LO update at edge T0+N.
  - `Busy` is low in the cycle after T0+N.
- HI/LO hold their old values throughout RUN.
- mthi/mtlo: HI/LO are visible the cycle after the issue edge; `Busy` never rises.
- Back-to-back issue: a new `Start` is accepted at edge T0+N+1 at the earliest.
  - On edge T0+N itself the unit is still in RUN, so that `Start` is ignored.
- Asserting `reset` mid-operation:
  - outputs go to their reset values without waiting for a clock edge;
  - the pending result is discarded.
  - After reset deasserts, the first `Start` is accepted normally.
- The stall condition for mfhi/mflo/mult-family in D/E is `Start|Busy`, computed outside this unit.

## Configuration

- Macro `HILO_MULDIV_MADD_EN`.
- Defined: opcodes 7–10 are multi-cycle accumulate ops with `MULT_CYCLES` latency.
- Undefined:
  - opcodes 7–10 are treated as reserved no-ops;
  - `Busy` stays 0 and HI/LO are unchanged;
  - no accumulate adder is synthesized.

## Test plan

- mult with `D1`=0xFFFFFFFF, `D2`=2 → `Busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div with `D1`=0xFFFFFFF9 (−7), `D2`=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with `D1`=7, `D2`=2 → LO=3, HI=1.
- Divide by zero: first mthi 0x1234 and mtlo 0x5678 (each visible next cycle, `Busy` stays 0), then div with `D2`=0 → `Busy` high 10 cycles, HI=0x1234, LO=0x5678 unchanged.
- Issue mult with `D1`=3, `D2`=4; pulse `Start` with mthi `D1`=0xAAAA at cycle 2 of RUN → pulse ignored; at completion HI=0, LO=12.
- Assert `reset` at cycle 4 of a div → `Busy`=0, HI=LO=0 immediately. A fresh divu 9/4 after release → LO=2, HI=1.
- With `HILO_MULDIV_MADD_EN`: HI=0, LO=5, then madd 3×4 → after 5 cycles LO=17, HI=0. Same stimulus without the macro → `Busy` stays 0, LO=5.
